alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_cmd_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 8-bit combinational ALU. It accepts a command, drives
// the ALU inputs, waits a programmable settle time, captures the result and returns it.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             cmd_clr_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int unsigned SET_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic             accept_c;
  logic             capture_c;
  logic             release_c;

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_chk
      $error("alu_cmd_sequencer: SETTLE must be in 1..15");
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and transaction strobes
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept_c  = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == '0) begin
          capture_c = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          release_c = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath; cmd_ready/busy mirror the next state so they stay registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      rsp_valid  <= 1'b0;
      rsp_f      <= '0;
      acc        <= '0;
      op_count   <= '0;
      settle_cnt <= '0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      if (accept_c) begin
        alu_s      <= cmd_op;
        alu_b      <= cmd_b;
        alu_a      <= cmd_clr_acc ? '0 : (cmd_use_acc ? acc : cmd_a);
        settle_cnt <= SET_W'(SETTLE - 1);
        if (cmd_clr_acc) begin
          acc <= '0;
        end
      end
      if (state == DRIVE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SET_W'(1);
      end
      if (capture_c) begin
        rsp_f     <= alu_f;
        acc       <= alu_f;
        rsp_valid <= 1'b1;
      end
      if (release_c) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two builds (SETTLE=1/CNT_W=4 and SETTLE=4/CNT_W=16),
// an XOR ALU stub, directed and random commands checked against a transaction model.
module tb_alu_cmd_sequencer;

  localparam int unsigned W   = 8;
  localparam int unsigned CW0 = 4;
  localparam int unsigned CW1 = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic         cmd_use_acc, cmd_clr_acc;

  logic         cmd_valid_v [2];
  logic         rsp_ready_v [2];
  logic         cmd_ready_v [2];
  logic         rsp_valid_v [2];
  logic         busy_v      [2];
  logic [W-1:0] alu_a_v     [2];
  logic [W-1:0] alu_b_v     [2];
  logic [W-1:0] alu_f_v     [2];
  logic [W-1:0] rsp_f_v     [2];
  logic [W-1:0] acc_v       [2];
  logic [2:0]   alu_s_v     [2];
  logic [CW0-1:0] op_count0;
  logic [CW1-1:0] op_count1;

  assign alu_f_v[0] = alu_a_v[0] ^ alu_b_v[0];
  assign alu_f_v[1] = alu_a_v[1] ^ alu_b_v[1];

  alu_cmd_sequencer #(.WIDTH(W), .SETTLE(1), .CNT_W(CW0)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready_v[0]), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_clr_acc(cmd_clr_acc),
    .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]), .alu_s(alu_s_v[0]), .alu_f(alu_f_v[0]),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]), .rsp_f(rsp_f_v[0]),
    .acc(acc_v[0]), .op_count(op_count0), .busy(busy_v[0])
  );

  alu_cmd_sequencer #(.WIDTH(W), .SETTLE(4), .CNT_W(CW1)) u_s4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready_v[1]), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_clr_acc(cmd_clr_acc),
    .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]), .alu_s(alu_s_v[1]), .alu_f(alu_f_v[1]),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]), .rsp_f(rsp_f_v[1]),
    .acc(acc_v[1]), .op_count(op_count1), .busy(busy_v[1])
  );

  int tests = 0;
  int fails = 0;

  // Reference model: per-build settle time, counter width, accumulator and completion count
  int unsigned  settle_m [2] = '{1, 4};
  int unsigned  cw_m     [2] = '{CW0, CW1};
  logic [W-1:0] m_acc    [2];
  int unsigned  m_cnt    [2];

  function automatic logic [31:0] get_cnt(input int m);
    return (m == 0) ? 32'(op_count0) : 32'(op_count1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int m);
    check("rst_cmd_ready", 32'(cmd_ready_v[m]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_v[m]), 32'd0);
    check("rst_busy",      32'(busy_v[m]),      32'd0);
    check("rst_alu",       32'({alu_s_v[m], alu_a_v[m], alu_b_v[m]}), 32'd0);
    check("rst_rsp_f_acc", 32'({rsp_f_v[m], acc_v[m]}), 32'd0);
    check("rst_op_count",  get_cnt(m), 32'd0);
  endtask

  // One full transaction: accept, settle, response with 'hold' cycles of backpressure
  task automatic do_op(input int m, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic use_acc, input logic clr_acc,
                       input int hold);
    logic [W-1:0] ea;
    logic [W-1:0] ef;
    int waitc;
    int lat;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_clr_acc = clr_acc;
    cmd_valid_v[m] = 1'b1;
    waitc = 0;
    while (!cmd_ready_v[m] && waitc < 20) begin
      tick();
      waitc++;
    end
    check("accept_wait", 32'(waitc), 32'd0);
    tick();
    cmd_valid_v[m] = 1'b0;
    ea = clr_acc ? '0 : (use_acc ? m_acc[m] : a);
    check("drive_alu", 32'({alu_s_v[m], alu_a_v[m], alu_b_v[m]}), 32'({op, ea, b}));
    check("drive_flags", 32'({cmd_ready_v[m], busy_v[m], rsp_valid_v[m]}), 32'b010);
    lat = 0;
    do begin
      rsp_ready_v[m] = 1'($urandom);
      tick();
      lat++;
      check("alu_hold", 32'({alu_s_v[m], alu_a_v[m], alu_b_v[m]}), 32'({op, ea, b}));
    end while (!rsp_valid_v[m] && lat < 40);
    check("latency", 32'(lat), 32'(settle_m[m]));
    ef = ea ^ b;
    m_acc[m] = ef;
    check("rsp_f", 32'(rsp_f_v[m]), 32'(ef));
    check("acc",   32'(acc_v[m]),   32'(ef));
    for (int i = 0; i < hold; i++) begin
      rsp_ready_v[m] = 1'b0;
      cmd_valid_v[m] = 1'b1;
      cmd_a = W'($urandom);
      cmd_b = ~b;
      tick();
      check("bp_hold", 32'({rsp_valid_v[m], cmd_ready_v[m], rsp_f_v[m]}), 32'({1'b1, 1'b0, ef}));
      check("bp_not_consumed", 32'(alu_b_v[m]), 32'(b));
    end
    rsp_ready_v[m] = 1'b1;
    tick();
    rsp_ready_v[m] = 1'b0;
    cmd_valid_v[m] = 1'b0;
    m_cnt[m] = (m_cnt[m] + 1) % (32'd1 << cw_m[m]);
    check("op_count", get_cnt(m), 32'(m_cnt[m]));
    check("idle_flags", 32'({cmd_ready_v[m], busy_v[m], rsp_valid_v[m]}), 32'b100);
    check("alu_kept", 32'(alu_a_v[m]), 32'(ea));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0; cmd_clr_acc = 1'b0;
    for (int m = 0; m < 2; m++) begin
      cmd_valid_v[m] = 1'b0;
      rsp_ready_v[m] = 1'b0;
      m_acc[m] = '0;
      m_cnt[m] = 0;
    end
    tick();
    tick();
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    tick();

    // Reset while the SETTLE=4 build is mid-drive: command is dropped
    cmd_a = 8'hAA; cmd_b = 8'h55; cmd_op = 3'b101;
    cmd_valid_v[1] = 1'b1;
    tick();
    cmd_valid_v[1] = 1'b0;
    check("pre_rst_busy", 32'(busy_v[1]), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset(1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      rsp_ready_v[1] = 1'($urandom);
      tick();
      if (rsp_valid_v[1]) seen++;
    end
    rsp_ready_v[1] = 1'b0;
    check("no_rsp_after_rst", 32'(seen), 32'd0);
    check("cnt_after_rst", get_cnt(1), 32'd0);

    // Basic op and accumulator chain on SETTLE=1 build
    do_op(0, 3'b000, 8'hAA, 8'h55, 1'b0, 1'b0, 0);
    check("basic_ff", 32'(rsp_f_v[0]), 32'h0FF);
    do_op(0, 3'b001, 8'h0F, 8'hF0, 1'b0, 1'b0, 0);
    do_op(0, 3'b010, 8'h00, 8'h0F, 1'b1, 1'b0, 0);
    check("chain_acc", 32'(acc_v[0]), 32'h0F0);
    do_op(0, 3'b011, 8'h5A, 8'h33, 1'b1, 1'b1, 0);
    check("clr_acc_rsp", 32'(rsp_f_v[0]), 32'h033);

    // Backpressure on SETTLE=4 build, followed immediately by a second command
    do_op(1, 3'b100, 8'h12, 8'h34, 1'b0, 1'b0, 5);
    do_op(1, 3'b110, 8'h77, 8'h0E, 1'b1, 1'b0, 0);

    // Counter wrap on the 4-bit counter build
    for (int i = 0; i < 17; i++) begin
      do_op(0, 3'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0);
    end

    // Random mix across both builds
    for (int i = 0; i < 24; i++) begin
      do_op(int'($urandom_range(1, 0)), 3'($urandom), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom_range(3, 0) == 0), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
